mandelbrot_iter_ctrl: RTL and testbench

Per-pixel iteration sequencer for the combinational Mandelbrot step ALU; one ALU step per clock. It accepts a pixel coordinate (cr, ci) via valid/ready and feeds the ALU with c and the current z. It counts iterations until escape (ALU size or overflow flag) or the iteration limit, then presents the count via valid/ready. It sits between the pixel/coordinate generator and the colour/output stage; the ALU is instantiated beside it by the parent.

---
 rtl/mandelbrot_iter_ctrl.sv | 151 +++++++++++++++
 tb/tb_mandelbrot_iter_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mandelbrot_iter_ctrl.sv
// Per-pixel iteration sequencer for an external combinational Mandelbrot step ALU.
// Define PERIODICITY_CHECK_EN to add saved-z cycle detection (early "inside" verdict).
module mandelbrot_iter_ctrl #(
    parameter int WIDTH      = 8,
    parameter int ITER_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  abort,
    input  logic [ITER_WIDTH-1:0] max_iter,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      in_cr,
    input  logic [WIDTH-1:0]      in_ci,
    output logic [WIDTH-1:0]      alu_cr,
    output logic [WIDTH-1:0]      alu_ci,
    output logic [WIDTH-1:0]      alu_zr,
    output logic [WIDTH-1:0]      alu_zi,
    input  logic [WIDTH-1:0]      alu_out_zr,
    input  logic [WIDTH-1:0]      alu_out_zi,
    input  logic                  alu_size,
    input  logic                  alu_overflow,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ITER_WIDTH-1:0] out_count,
    output logic                  out_escaped,
    output logic                  out_periodic,
    output logic                  busy
);
    typedef enum logic [1:0] {S_IDLE, S_ITER, S_DONE} state_t;

    state_t                state, state_nxt;
    logic [WIDTH-1:0]      cr_q, ci_q, zr_q, zi_q;
    logic [ITER_WIDTH-1:0] iter_q, lim_q, count_q, iter_inc, fin_count;
    logic                  escaped_q, fin_esc;
    logic                  accept, escape, at_limit, periodic_hit, do_step, do_fin;

    // DONE can take the next pixel in the same cycle its result is consumed.
    assign in_ready = !abort && ((state == S_IDLE) || ((state == S_DONE) && out_ready));
    assign accept   = in_valid && in_ready;
    assign escape   = alu_size || alu_overflow;
    assign iter_inc = iter_q + ITER_WIDTH'(1);
    assign at_limit = (iter_inc == lim_q);

    assign alu_cr      = cr_q;
    assign alu_ci      = ci_q;
    assign alu_zr      = zr_q;
    assign alu_zi      = zi_q;
    assign out_valid   = (state == S_DONE);
    assign busy        = (state != S_IDLE);
    assign out_count   = count_q;
    assign out_escaped = escaped_q;

    always_comb begin
        state_nxt = state;
        do_step   = 1'b0;
        do_fin    = 1'b0;
        fin_count = lim_q;
        fin_esc   = 1'b0;
        case (state)
            S_IDLE: if (accept) state_nxt = (max_iter == '0) ? S_DONE : S_ITER;
            S_ITER: begin
                if (escape) begin
                    state_nxt = S_DONE;
                    do_fin    = 1'b1;
                    fin_count = iter_q;
                    fin_esc   = 1'b1;
                end else if (at_limit || periodic_hit) begin
                    state_nxt = S_DONE;
                    do_fin    = 1'b1;
                end else begin
                    do_step = 1'b1;
                end
            end
            S_DONE: begin
                if (accept)         state_nxt = (max_iter == '0) ? S_DONE : S_ITER;
                else if (out_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
        if (abort) begin
            state_nxt = S_IDLE;
            do_step   = 1'b0;
            do_fin    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cr_q      <= '0;
            ci_q      <= '0;
            zr_q      <= '0;
            zi_q      <= '0;
            iter_q    <= '0;
            lim_q     <= '0;
            count_q   <= '0;
            escaped_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                cr_q      <= in_cr;
                ci_q      <= in_ci;
                zr_q      <= '0;
                zi_q      <= '0;
                iter_q    <= '0;
                lim_q     <= max_iter;
                count_q   <= '0;
                escaped_q <= 1'b0;
            end else if (do_step) begin
                zr_q   <= alu_out_zr;
                zi_q   <= alu_out_zi;
                iter_q <= iter_inc;
            end else if (do_fin) begin
                count_q   <= fin_count;
                escaped_q <= fin_esc;
            end
        end
    end

`ifdef PERIODICITY_CHECK_EN
    logic [WIDTH-1:0] szr_q, szi_q;
    logic             periodic_q, iter_pow2;

    // Snapshot z at power-of-two steps; a later exact repeat means an orbit cycle.
    assign iter_pow2    = (iter_q != '0) && ((iter_q & (iter_q - ITER_WIDTH'(1))) == '0);
    assign periodic_hit = (iter_q != '0) && !iter_pow2 && (zr_q == szr_q) && (zi_q == szi_q);
    assign out_periodic = periodic_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            szr_q      <= '0;
            szi_q      <= '0;
            periodic_q <= 1'b0;
        end else if (accept) begin
            szr_q      <= '0;
            szi_q      <= '0;
            periodic_q <= 1'b0;
        end else begin
            if (do_step && iter_pow2) begin
                szr_q <= zr_q;
                szi_q <= zi_q;
            end
            if (do_fin) periodic_q <= !escape && !at_limit;
        end
    end
`else
    assign periodic_hit = 1'b0;
    assign out_periodic = 1'b0;
`endif
endmodule

// File: tb/tb_mandelbrot_iter_ctrl.sv
// Randomized bench for mandelbrot_iter_ctrl with a fixed-point step ALU and an orbit-level reference model.
module tb_mandelbrot_iter_ctrl;
    localparam int W  = 8;
    localparam int IW = 8;
    localparam int FB = W - 2;

    logic          clk = 1'b0;
    logic          rst_n, abort, in_valid, out_ready;
    logic [IW-1:0] max_iter;
    logic [W-1:0]  in_cr, in_ci, alu_cr, alu_ci, alu_zr, alu_zi, alu_out_zr, alu_out_zi;
    logic          alu_size, alu_overflow, in_ready, out_valid, out_escaped, out_periodic, busy;
    logic [IW-1:0] out_count;

    int n_tests = 0;
    int n_fail  = 0;
    int step_k  = 0;
    int force_k = -1;
    int zs_r [0:511];
    int zs_i [0:511];
    int exp_cnt, exp_lat;
    bit exp_esc, exp_per;

    mandelbrot_iter_ctrl #(.WIDTH(W), .ITER_WIDTH(IW)) dut (
        .clk(clk), .rst_n(rst_n), .abort(abort), .max_iter(max_iter),
        .in_valid(in_valid), .in_ready(in_ready), .in_cr(in_cr), .in_ci(in_ci),
        .alu_cr(alu_cr), .alu_ci(alu_ci), .alu_zr(alu_zr), .alu_zi(alu_zi),
        .alu_out_zr(alu_out_zr), .alu_out_zi(alu_out_zi),
        .alu_size(alu_size), .alu_overflow(alu_overflow),
        .out_valid(out_valid), .out_ready(out_ready), .out_count(out_count),
        .out_escaped(out_escaped), .out_periodic(out_periodic), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic int sx(input logic [W-1:0] v);
        return int'($signed(v));
    endfunction
    function automatic int wrap(input int v);
        logic [W-1:0] t;
        t = v[W-1:0];
        return sx(t);
    endfunction
    function automatic bit fits(input int v);
        return (v >= -(1 << (W-1))) && (v < (1 << (W-1)));
    endfunction
    function automatic int raw_r(input int zr, input int zi, input int cr);
        return ((zr*zr - zi*zi) >>> FB) + cr;
    endfunction
    function automatic int raw_i(input int zr, input int zi, input int ci);
        return ((2*zr*zi) >>> FB) + ci;
    endfunction
    function automatic bit big(input int zr, input int zi);
        return (zr*zr + zi*zi) > (4 << (2*FB));
    endfunction
    function automatic bit pow2(input int k);
        return (k > 0) && ((k & (k-1)) == 0);
    endfunction

    // Step ALU seen by the DUT; force_k injects an escape at a chosen step of the current pixel.
    always_comb begin
        alu_out_zr   = W'(raw_r(sx(alu_zr), sx(alu_zi), sx(alu_cr)));
        alu_out_zi   = W'(raw_i(sx(alu_zr), sx(alu_zi), sx(alu_ci)));
        alu_overflow = !fits(raw_r(sx(alu_zr), sx(alu_zi), sx(alu_cr))) ||
                       !fits(raw_i(sx(alu_zr), sx(alu_zi), sx(alu_ci)));
        alu_size     = big(sx(alu_zr), sx(alu_zi)) || (step_k == force_k);
    end

    always @(posedge clk) step_k <= (in_valid && in_ready) ? 0 : step_k + 1;

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Orbit of z = z^2 + c; outputs expected count/flags, edges to out_valid, and z per step.
    task automatic model(input int cr, input int ci, input int lim, input int fk);
        int zr, zi, nr, ni, szr, szi;
        zr = 0; zi = 0; szr = 0; szi = 0;
        exp_esc = 0; exp_per = 0; exp_cnt = 0; exp_lat = 0;
        for (int k = 0; k < lim; k++) begin
            zs_r[k] = zr; zs_i[k] = zi;
            nr = raw_r(zr, zi, cr); ni = raw_i(zr, zi, ci);
            if (big(zr, zi) || !fits(nr) || !fits(ni) || k == fk) begin
                exp_cnt = k; exp_esc = 1; exp_lat = k + 1; return;
            end
            if (k + 1 == lim) begin
                exp_cnt = lim; exp_lat = lim; return;
            end
`ifdef PERIODICITY_CHECK_EN
            if (k > 0 && !pow2(k) && zr == szr && zi == szi) begin
                exp_cnt = lim; exp_per = 1; exp_lat = k + 1; return;
            end
            if (pow2(k)) begin szr = zr; szi = zi; end
`endif
            zr = wrap(nr); zi = wrap(ni);
        end
    endtask

    task automatic accept_pixel(input int cr, input int ci, input int mi, input int fk);
        model(wrap(cr), wrap(ci), mi, fk);
        force_k  = fk;
        in_valid = 1'b1; in_cr = W'(cr); in_ci = W'(ci); max_iter = IW'(mi);
        #1 chk("in_ready_at_accept", in_ready, 1);
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0;
        in_cr = W'($urandom); in_ci = W'($urandom); max_iter = IW'($urandom);
        #1;
    endtask

    task automatic wait_result();
        int e = 0;
        while (!out_valid && e < 300) begin
            if (e < exp_lat) begin
                chk("alu_zr", sx(alu_zr), zs_r[e]);
                chk("alu_zi", sx(alu_zi), zs_i[e]);
            end
            chk("in_ready_iter", in_ready, 0);
            in_valid = 1'($urandom);
            @(posedge clk); @(negedge clk);
            e++;
        end
        in_valid = 1'b0;
        #1;
        chk("out_valid", out_valid, 1);
        chk("latency", e, exp_lat);
        chk("count", out_count, exp_cnt);
        chk("escaped", out_escaped, exp_esc);
        chk("periodic", out_periodic, exp_per);
    endtask

    task automatic hold_check(input int n);
        repeat (n) begin
            @(posedge clk); @(negedge clk); #1;
            chk("hold_valid", out_valid, 1);
            chk("hold_count", out_count, exp_cnt);
            chk("hold_escaped", out_escaped, exp_esc);
            chk("hold_periodic", out_periodic, exp_per);
            chk("hold_in_ready", in_ready, 0);
        end
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        #1 chk("in_ready_done", in_ready, 1);
        @(posedge clk); @(negedge clk);
        out_ready = 1'b0;
        #1;
        chk("idle_valid", out_valid, 0);
        chk("idle_busy", busy, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit pending;
        rst_n = 1'b0; abort = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_cr = '0; in_ci = '0; max_iter = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_alu_cr", alu_cr, 0);
        chk("rst_alu_zr", alu_zr, 0);
        chk("rst_count", out_count, 0);
        chk("rst_escaped", out_escaped, 0);
        chk("rst_periodic", out_periodic, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Forced escape at k=5, then limit case with c=0.
        accept_pixel(8'h10, 8'h08, 16, 5); wait_result(); release_result();
        accept_pixel(0, 0, 16, -1);        wait_result(); release_result();

        // Zero limit: result straight away, held while downstream stalls.
        accept_pixel(8'h20, 8'h10, 0, -1); wait_result(); hold_check(5); release_result();

        // Back-to-back: consume a result and accept the next pixel on the same edge.
        accept_pixel(8'h30, 8'h05, 10, -1); wait_result();
        out_ready = 1'b1;
        accept_pixel(0, 0, 16, 3);
        chk("b2b_busy", busy, 1);
        chk("b2b_valid", out_valid, 0);
        wait_result(); release_result();

        // Abort at k=3 with a competing request.
        accept_pixel(0, 0, 16, -1);
        repeat (3) begin @(posedge clk); @(negedge clk); end
        abort = 1'b1; in_valid = 1'b1; in_cr = 8'h11; in_ci = 8'h22; max_iter = 8'd9;
        #1 chk("abort_in_ready", in_ready, 0);
        @(posedge clk); @(negedge clk);
        abort = 1'b0; in_valid = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_in_ready_after", in_ready, 1);
        repeat (4) begin
            chk("abort_no_valid", out_valid, 0);
            @(posedge clk); @(negedge clk); #1;
        end
        accept_pixel(8'hE0, 8'h18, 20, -1); wait_result(); release_result();

        // Asynchronous reset in the middle of an orbit.
        accept_pixel(8'h08, 8'h04, 30, -1);
        repeat (3) begin @(posedge clk); @(negedge clk); end
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_in_ready", in_ready, 1);
        chk("mid_rst_zr", alu_zr, 0);
        chk("mid_rst_zi", alu_zi, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Random pixels, limits, forced escapes, stalls and back-to-back hand-offs.
        pending = 1'b0;
        for (int i = 0; i < 40; i++) begin
            int mi, fk;
            mi = $urandom_range(0, 40);
            fk = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 40) : -1;
            if (pending) begin
                if ($urandom_range(0, 1) == 1) out_ready = 1'b1;
                else release_result();
            end
            accept_pixel(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), mi, fk);
            wait_result();
            hold_check($urandom_range(0, 2));
            pending = 1'b1;
        end
        release_result();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
